// File: rtl/piso_shift_reader.sv
// piso_shift_reader: loads a parallel word on a w strobe and streams it out
// LSB first over a valid/ready handshake, then pulses done for one cycle.
//
// state | meaning
// IDLE  | waiting for w; q and valid low, busy low
// SHIFT | q/valid present sreg[0]; each accepted bit shifts the word right
// DONE  | one-cycle done pulse after the final bit, then back to IDLE
module piso_shift_reader #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  input  logic             w,
  input  logic             ready,
  output logic             q,
  output logic             valid,
  output logic             busy,
  output logic             done
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] sreg;
  logic [CW-1:0]    cnt;
  logic             load;
  logic             accept;

  // State register; reset aborts any transfer without a done pulse.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and outputs; outputs decode only registered state, so q has
  // no combinational path from d.
  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    accept    = 1'b0;
    q         = 1'b0;
    valid     = 1'b0;
    busy      = 1'b1;
    done      = 1'b0;
    case (state)
      IDLE: begin
        busy = 1'b0;
        // A load in IDLE never consumes a bit, even with ready high.
        if (w) begin
          load      = 1'b1;
          state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        valid = 1'b1;
        q     = sreg[0];
        if (ready) begin
          accept = 1'b1;
          if (cnt == LAST) begin
            state_nxt = DONE;
          end
        end
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: begin
        busy      = 1'b0;
        state_nxt = IDLE;
      end
    endcase
  end

  // Shift register and bit counter; both hold when nothing is loaded or accepted.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sreg <= '0;
      cnt  <= '0;
    end else if (load) begin
      sreg <= d;
      cnt  <= '0;
    end else if (accept) begin
      sreg <= sreg >> 1;
      cnt  <= cnt + CW'(1);
    end
  end

endmodule
